lcd_write_scheduler: RTL and testbench

- Sequences all writes to the LCD1602 character display and shares it between several field producers, e.g. frequency digits, FFT point count and note name.
- After reset it runs a power-on delay, then the HD44780 init commands. It then grants requesters round-robin.
- For each grant it emits a set-DDRAM-address command followed by the field's characters.
- Output is a byte stream on a valid/ready handshake to the downstream LCD bus-timing engine, which generates E pulses and execution waits.

---
 rtl/lcd_write_scheduler.sv | 222 ++++++++++++++++++++++
 tb/tb_lcd_write_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_write_scheduler.sv
// Serialises LCD1602 writes: power-on wait, HD44780 init, then round-robin
// field requests, each emitted as a set-DDRAM-address command plus characters.
module lcd_write_scheduler #(
    parameter int N_REQ      = 3,
    parameter int MAX_CHARS  = 8,
    parameter int POR_CYCLES = 500000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    input  logic [7*N_REQ-1:0]           req_addr,
    input  logic [4*N_REQ-1:0]           req_len,
    input  logic [8*MAX_CHARS*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]             req_ack,
    output logic [N_REQ-1:0]             grant,
    output logic                         bus_valid,
    input  logic                         bus_ready,
    output logic                         bus_rs,
    output logic [7:0]                   bus_data,
    output logic                         bus_long,
    output logic                         init_done,
    output logic                         busy
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LW = $clog2(MAX_CHARS + 1);
    localparam int CW = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam int DW = 8 * MAX_CHARS;

    typedef enum logic [2:0] {S_POR, S_INIT, S_ARB, S_ADDR, S_CHAR, S_DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     por_cnt_q;
    logic [1:0]        init_idx_q;
    logic [PW-1:0]     ptr_q;
    logic [6:0]        addr_q;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     idx_q;
    logic [DW-1:0]     data_q;
    logic [N_REQ-1:0]  grant_q;
    logic [N_REQ-1:0]  req_ack_q;
    logic              bus_valid_q;
    logic              bus_rs_q;
    logic [7:0]        bus_data_q;
    logic              bus_long_q;
    logic              init_done_q;
    logic              busy_q;

    logic              xfer;
    logic [N_REQ-1:0]  cand;
    logic [PW:0]       arb_sum;
    logic              win_vld_d;
    logic [PW-1:0]     win_idx_d;
    logic [PW-1:0]     ptr_d;
    logic [6:0]        win_addr_d;
    logic [3:0]        win_len_raw;
    logic [LW-1:0]     win_len_d;
    logic [DW-1:0]     win_data_d;
    logic [LW-1:0]     idx_nxt;
    logic [1:0]        init_nxt;

    assign xfer     = bus_valid_q & bus_ready;
    assign idx_nxt  = idx_q + 1'b1;
    assign init_nxt = init_idx_q + 2'd1;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h06;
            default: init_cmd = 8'h01;
        endcase
    endfunction

    // Byte 0 is the most significant byte of the latched field.
    function automatic logic [7:0] char_at(input logic [DW-1:0] d, input logic [LW-1:0] i);
        char_at = d[DW-8-8*int'(i) +: 8];
    endfunction

    // Round-robin search from ptr_q; a requester whose ack is on the bus this
    // cycle still shows req_valid, so it is masked to avoid a duplicate grant.
    always_comb begin
        cand      = req_valid & ~req_ack_q;
        win_vld_d = 1'b0;
        win_idx_d = '0;
        arb_sum   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            arb_sum = {1'b0, ptr_q} + (PW+1)'(off);
            if (arb_sum >= (PW+1)'(N_REQ))
                arb_sum = arb_sum - (PW+1)'(N_REQ);
            if (cand[arb_sum[PW-1:0]]) begin
                win_vld_d = 1'b1;
                win_idx_d = arb_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        ptr_d       = (int'(win_idx_d) == N_REQ - 1) ? '0 : win_idx_d + 1'b1;
        win_addr_d  = req_addr[7*int'(win_idx_d) +: 7];
        win_len_raw = req_len[4*int'(win_idx_d) +: 4];
        win_data_d  = req_data[DW*int'(win_idx_d) +: DW];
        if (int'(win_len_raw) > MAX_CHARS)
            win_len_d = LW'(MAX_CHARS);
        else
            win_len_d = LW'(win_len_raw);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_POR;
            por_cnt_q   <= '0;
            init_idx_q  <= '0;
            ptr_q       <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            grant_q     <= '0;
            req_ack_q   <= '0;
            bus_valid_q <= 1'b0;
            bus_rs_q    <= 1'b0;
            bus_data_q  <= '0;
            bus_long_q  <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            req_ack_q <= '0;
            case (state_q)
                S_POR: begin
                    busy_q <= 1'b1;
                    if (por_cnt_q == CW'(POR_CYCLES - 1)) begin
                        por_cnt_q   <= '0;
                        init_idx_q  <= '0;
                        state_q     <= S_INIT;
                        bus_valid_q <= 1'b1;
                        bus_rs_q    <= 1'b0;
                        bus_data_q  <= init_cmd(2'd0);
                        bus_long_q  <= 1'b0;
                    end else begin
                        por_cnt_q <= por_cnt_q + 1'b1;
                    end
                end
                S_INIT: begin
                    if (xfer) begin
                        if (init_idx_q == 2'd3) begin
                            bus_valid_q <= 1'b0;
                            bus_data_q  <= '0;
                            bus_long_q  <= 1'b0;
                            init_done_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_ARB;
                        end else begin
                            init_idx_q <= init_nxt;
                            bus_data_q <= init_cmd(init_nxt);
                            bus_long_q <= (init_nxt == 2'd3);
                        end
                    end
                end
                S_ARB: begin
                    if (win_vld_d) begin
                        addr_q      <= win_addr_d;
                        len_q       <= win_len_d;
                        data_q      <= win_data_d;
                        grant_q     <= N_REQ'(1) << win_idx_d;
                        ptr_q       <= ptr_d;
                        state_q     <= S_ADDR;
                        busy_q      <= 1'b1;
                        bus_valid_q <= 1'b1;
                        bus_rs_q    <= 1'b0;
                        bus_data_q  <= {1'b1, win_addr_d};
                        bus_long_q  <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (xfer) begin
                        if (len_q == '0) begin
                            bus_valid_q <= 1'b0;
                            bus_data_q  <= '0;
                            state_q     <= S_DONE;
                        end else begin
                            idx_q      <= '0;
                            bus_rs_q   <= 1'b1;
                            bus_data_q <= char_at(data_q, '0);
                            state_q    <= S_CHAR;
                        end
                    end
                end
                S_CHAR: begin
                    if (xfer) begin
                        idx_q <= idx_nxt;
                        if (idx_nxt == len_q) begin
                            bus_valid_q <= 1'b0;
                            bus_rs_q    <= 1'b0;
                            bus_data_q  <= '0;
                            state_q     <= S_DONE;
                        end else begin
                            bus_data_q <= char_at(data_q, idx_nxt);
                        end
                    end
                end
                S_DONE: begin
                    req_ack_q <= grant_q;
                    grant_q   <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= S_ARB;
                end
                default: state_q <= S_POR;
            endcase
        end
    end

    assign req_ack   = req_ack_q;
    assign grant     = grant_q;
    assign bus_valid = bus_valid_q;
    assign bus_rs    = bus_rs_q;
    assign bus_data  = bus_data_q;
    assign bus_long  = bus_long_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_write_scheduler.sv
// Scoreboard bench for lcd_write_scheduler: expected bus bytes are queued as
// requests are driven and compared as each transfer completes.
module tb_lcd_write_scheduler;

    localparam int N   = 3;
    localparam int MC  = 8;
    localparam int POR = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [7*N-1:0]    req_addr  = '0;
    logic [4*N-1:0]    req_len   = '0;
    logic [8*MC*N-1:0] req_data  = '0;
    logic [N-1:0]      req_ack;
    logic [N-1:0]      grant;
    logic              bus_valid;
    logic              bus_ready = 1'b1;
    logic              bus_rs;
    logic [7:0]        bus_data;
    logic              bus_long;
    logic              init_done;
    logic              busy;

    lcd_write_scheduler #(.N_REQ(N), .MAX_CHARS(MC), .POR_CYCLES(POR)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
        .req_ack(req_ack), .grant(grant),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_rs(bus_rs),
        .bus_data(bus_data), .bus_long(bus_long),
        .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [12:0] sb[$];        // {grant, rs, long, data}
    logic [2:0]  glog[$];
    int          ack_cnt[N];
    int          xfers = 0;
    bit          keep_valid = 0;
    bit          rnd_rdy = 0;
    bit          pend = 0;
    logic [9:0]  pend_byte = '0;
    logic [2:0]  prev_grant = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_init();
        sb.push_back({3'b000, 2'b00, 8'h38});
        sb.push_back({3'b000, 2'b00, 8'h0C});
        sb.push_back({3'b000, 2'b00, 8'h06});
        sb.push_back({3'b000, 2'b01, 8'h01});
    endtask

    task automatic push_req(input int g, input logic [6:0] a, input logic [3:0] len, input logic [63:0] d);
        logic [2:0] gv;
        int eff;
        gv  = 3'(1 << g);
        eff = (int'(len) > MC) ? MC : int'(len);
        sb.push_back({gv, 2'b00, 1'b1, a});
        for (int c = 0; c < eff; c++)
            sb.push_back({gv, 2'b10, d[63-8*c -: 8]});
    endtask

    task automatic drive_req(input int i, input logic [6:0] a, input logic [3:0] len, input logic [63:0] d);
        req_addr[7*i +: 7] = a;
        req_len[4*i +: 4]  = len;
        req_data[64*i +: 64] = d;
        req_valid[i] = 1'b1;
        push_req(i, a, len, d);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (n < budget && !(sb.size() == 0 && !busy && !bus_valid && req_valid == '0)) begin
            @(negedge clk);
            n++;
        end
        chk(tag, n < budget, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic por_latency(input string tag);
        int n;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (bus_valid) break;
        end
        chk(tag, n, POR);
    endtask

    // Monitor: scoreboard pop, stall stability, acks and grant order.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (pend)
                chk("stall_stable", {bus_valid, bus_rs, bus_long, bus_data}, {1'b1, pend_byte});
            pend      = bus_valid && !bus_ready;
            pend_byte = {bus_rs, bus_long, bus_data};
            if (bus_valid && bus_ready) begin
                xfers++;
                chk("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0)
                    chk("byte", {grant, bus_rs, bus_long, bus_data}, sb.pop_front());
            end
            for (int i = 0; i < N; i++)
                if (req_ack[i]) ack_cnt[i]++;
            if (grant != prev_grant && grant != '0)
                glog.push_back(grant);
            prev_grant = grant;
        end else begin
            pend       = 0;
            prev_grant = '0;
        end
    end

    // Downstream ready pattern and requester drop-on-ack.
    initial forever begin
        @(posedge clk);
        #1;
        bus_ready = rnd_rdy ? ($urandom_range(0, 9) < 3) : 1'b1;
        #1;
        if (!keep_valid)
            req_valid = req_valid & ~req_ack;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, x0, a0, n;
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;

        // Reset state, then a request raised during POR must wait for init.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {bus_valid, bus_rs, bus_long, bus_data, req_ack, grant, init_done, busy}, 0);
        @(negedge clk);
        rst = 1'b0;
        push_init();
        drive_req(0, 7'h40, 4'd8, "12345 Hz");
        por_latency("por_lat");
        wait_done("t2_done", 400);
        chk("init_done", init_done, 1);
        chk("t2_ack", ack_cnt[0], 1);
        chk("t2_grant", glog.size() > 0 ? glog[0] : 3'b0, 3'b001);

        // Clamp: len 15 -> 1 + 8 bytes, ack after eff+3 cycles; moves pointer back to 0.
        @(posedge clk);
        #1;
        x0 = xfers;
        drive_req(2, 7'h10, 4'd15, "ABCDEFGH");
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (req_ack[2]) break;
        end
        chk("clamp_lat", n, 11);
        wait_done("t5_done", 100);
        chk("clamp_xfers", xfers - x0, 9);
        chk("clamp_ack", ack_cnt[2], 1);

        // Fairness with all three held valid.
        @(posedge clk);
        #1;
        keep_valid = 1;
        g0 = glog.size();
        drive_req(0, 7'h00, 4'd4, {"ABCD", 32'h0});
        drive_req(1, 7'h45, 4'd3, {"xyz", 40'h0});
        drive_req(2, 7'h0A, 4'd0, 64'h0);
        push_req(0, 7'h00, 4'd4, {"ABCD", 32'h0});
        n = 0;
        while (n < 200 && glog.size() < g0 + 4) begin
            @(negedge clk);
            n++;
        end
        chk("rr_4grants", glog.size() >= g0 + 4, 1);
        @(posedge clk);
        #1;
        req_valid  = '0;
        keep_valid = 0;
        wait_done("t3_done", 200);
        if (glog.size() >= g0 + 4) begin
            chk("rr_g0", glog[g0],   3'b001);
            chk("rr_g1", glog[g0+1], 3'b010);
            chk("rr_g2", glog[g0+2], 3'b100);
            chk("rr_g3", glog[g0+3], 3'b001);
        end
        chk("rr_acks", {ack_cnt[0], ack_cnt[1], ack_cnt[2]}, {32'd3, 32'd1, 32'd2});

        // Random backpressure on a 5-char request.
        @(posedge clk);
        #1;
        x0 = xfers;
        rnd_rdy = 1;
        drive_req(1, 7'h4B, 4'd5, {"Hello", 24'h0});
        wait_done("t4_done", 600);
        rnd_rdy = 0;
        chk("stall_xfers", xfers - x0, 6);
        chk("stall_ack", ack_cnt[1], 2);

        // Reset while presenting char index 3.
        @(posedge clk);
        #1;
        a0 = ack_cnt[0];
        drive_req(0, 7'h00, 4'd8, "abcdefgh");
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (bus_valid && bus_rs && bus_data == 8'h64) break;
        end
        chk("mid_reached", n < 50, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid", {bus_valid, bus_rs, bus_long, bus_data, req_ack, grant, init_done, busy}, 0);
        sb.delete();
        repeat (3) @(posedge clk);
        chk("rst_no_ack", ack_cnt[0], a0);
        @(negedge clk);
        rst = 1'b0;
        push_init();
        push_req(0, 7'h00, 4'd8, "abcdefgh");
        por_latency("por_lat2");
        wait_done("t6_done", 400);
        chk("rst_reack", ack_cnt[0] - a0, 1);
        chk("init_done2", init_done, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
